repeated_sub_divider: RTL and testbench

Unsigned integer divider using repeated subtraction. It loads a divisor and then a dividend over one shared 16-bit input bus, then subtracts the divisor from a running remainder once per cycle, counting iterations into the quotient. It is a self-contained datapath plus controller pair, used wherever a slow, small-area divide is acceptable. It signals completion with a level `done` flag.

---
 rtl/repeated_sub_divider_pkg.sv | 13 +
 rtl/repeated_sub_divider_if.sv | 24 ++
 rtl/repeated_sub_divider_ctrl.sv | 76 +++++++
 rtl/repeated_sub_divider.sv | 74 +++++++
 tb/tb_repeated_sub_divider.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/repeated_sub_divider_pkg.sv
// Shared types and constants for the repeated-subtraction divider.
package repeated_sub_divider_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    CALC   = 2'd2,
    DONE   = 2'd3
  } div_state_t;

endpackage

// File: rtl/repeated_sub_divider_if.sv
// Operand/result bundle of the divider; master drives operands, slave returns results.
interface repeated_sub_divider_if
  import repeated_sub_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             dz;

  modport master (
    output start, data_in,
    input  busy, done, quotient, remainder, dz
  );

  modport slave (
    input  start, data_in,
    output busy, done, quotient, remainder, dz
  );
endinterface

// File: rtl/repeated_sub_divider_ctrl.sv
// Controller FSM of the divider: sequences divisor load, dividend load and subtraction loop.
// Optional DIV_ZERO_DETECT_EN short-circuits a zero divisor straight to DONE.
module repeated_sub_divider_ctrl
  import repeated_sub_divider_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic r_ge_b,
  input  logic q_sat,
  input  logic b_zero,
  output logic load_b,
  output logic load_r,
  output logic sub_en,
  output logic inc_en,
  output logic set_dz,
  output logic sat_q,
  output logic busy,
  output logic done
);

  div_state_t state, state_next;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_b     = 1'b0;
    load_r     = 1'b0;
    sub_en     = 1'b0;
    inc_en     = 1'b0;
    set_dz     = 1'b0;
    sat_q      = 1'b0;
    busy       = (state == LOAD_A) || (state == CALC);
    done       = (state == DONE);

    case (state)
      IDLE, DONE: begin
        if (start) begin
          load_b     = 1'b1;
          state_next = LOAD_A;
        end
      end
      LOAD_A: begin
        load_r     = 1'b1;
        state_next = CALC;
`ifdef DIV_ZERO_DETECT_EN
        if (b_zero) begin
          set_dz     = 1'b1;
          sat_q      = 1'b1;
          state_next = DONE;
        end
`endif
      end
      CALC: begin
        // Saturating Q bounds the loop even when the divisor is zero
        if (r_ge_b && !q_sat) begin
          sub_en = 1'b1;
          inc_en = 1'b1;
        end else begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifndef DIV_ZERO_DETECT_EN
  logic unused_b_zero;
  assign unused_b_zero = b_zero;
`endif

endmodule

// File: rtl/repeated_sub_divider.sv
// Unsigned repeated-subtraction divider: B/R/Q datapath plus controller instance.
// Define DIV_ZERO_DETECT_EN to flag a zero divisor with dz and finish early.
module repeated_sub_divider
  import repeated_sub_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                   clk,
  input logic                   rst_n,
  repeated_sub_divider_if.slave bus
);

  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic             dz_q;

  logic r_ge_b, q_sat, b_zero;
  logic load_b, load_r, sub_en, inc_en, set_dz, sat_q;
  logic busy, done;

  assign r_ge_b = (r_q >= b_q);
  assign q_sat  = &q_q;
  assign b_zero = (b_q == '0);

  repeated_sub_divider_ctrl u_ctrl (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (bus.start),
    .r_ge_b (r_ge_b),
    .q_sat  (q_sat),
    .b_zero (b_zero),
    .load_b (load_b),
    .load_r (load_r),
    .sub_en (sub_en),
    .inc_en (inc_en),
    .set_dz (set_dz),
    .sat_q  (sat_q),
    .busy   (busy),
    .done   (done)
  );

  // Enables come from mutually exclusive FSM states, so at most one write per register per edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_q  <= '0;
      r_q  <= '0;
      q_q  <= '0;
      dz_q <= 1'b0;
    end else begin
      if (load_b) begin
        b_q  <= bus.data_in;
        q_q  <= '0;
        dz_q <= 1'b0;
      end
      if (load_r) r_q <= bus.data_in;
      if (sub_en) r_q <= r_q - b_q;
      if (inc_en) q_q <= q_q + WIDTH'(1);
      if (sat_q)  q_q <= '1;
      if (set_dz) dz_q <= 1'b1;
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.quotient  = q_q;
  assign bus.remainder = r_q;
`ifdef DIV_ZERO_DETECT_EN
  assign bus.dz        = dz_q;
`else
  assign bus.dz        = 1'b0;
`endif

endmodule

// File: tb/tb_repeated_sub_divider.sv
// Self-checking bench for repeated_sub_divider against an arithmetic model (honours DIV_ZERO_DETECT_EN).
module tb_repeated_sub_divider;

  localparam int W = 16;
  localparam int MAX_WAIT = 70000;

  logic clk;
  logic rst_n;

  repeated_sub_divider_if #(.WIDTH(W)) bus_if ();

  repeated_sub_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q, exp_r;
  logic         exp_dz;
  int           exp_lat;
  bit           exp_valid = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Division semantics from plain arithmetic; latency counted in edges after the start edge
  function automatic void model(input logic [W-1:0] b, input logic [W-1:0] a,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz_o, output int lat);
    int qi;
    if (b == 0) begin
      q = {W{1'b1}};
      r = a;
`ifdef DIV_ZERO_DETECT_EN
      dz_o = 1'b1;
      lat  = 1;
`else
      dz_o = 1'b0;
      lat  = (1 << W) + 1;
`endif
    end else begin
      qi   = int'(a) / int'(b);
      q    = W'(qi);
      r    = W'(int'(a) % int'(b));
      dz_o = 1'b0;
      lat  = qi + 2;
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("busy_done_exclusive", int'(bus_if.busy && bus_if.done), 0);
      if (exp_valid && bus_if.done) begin
        checkOutput("quotient", bus_if.quotient, exp_q);
        checkOutput("remainder", bus_if.remainder, exp_r);
        checkOutput("dz", bus_if.dz, exp_dz);
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] b, input logic [W-1:0] a, input bit pulse);
    int  lat;
    bit  got;
    @(posedge clk); #1;
    exp_valid      = 1'b0;
    bus_if.start   = 1'b1;
    bus_if.data_in = b;
    @(posedge clk); #1;
    bus_if.start   = 1'b0;
    bus_if.data_in = a;
    model(b, a, exp_q, exp_r, exp_dz, exp_lat);
    exp_valid = 1'b1;
    checkOutput("busy_after_start", bus_if.busy, 1);
    checkOutput("done_cleared", bus_if.done, 0);
    lat = 0;
    got = 1'b0;
    while (lat < MAX_WAIT && !got) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) bus_if.data_in = W'($urandom);
      if (pulse && lat == 3) begin
        bus_if.start   = 1'b1;
        bus_if.data_in = W'($urandom);
      end
      if (pulse && lat == 4) bus_if.start = 1'b0;
      if (bus_if.done) got = 1'b1;
    end
    bus_if.start = 1'b0;
    if (!got) checkOutput("done_timeout", bus_if.done, 1);
    checkOutput("latency", lat, exp_lat);
  endtask

  task automatic runDirected(input logic [W-1:0] b, input logic [W-1:0] a,
                             input int lit_q, input int lit_r, input bit pulse);
    applyStimulus(b, a, pulse);
    checkOutput("model_q_pin", exp_q, lit_q);
    checkOutput("lit_quotient", bus_if.quotient, lit_q);
    checkOutput("lit_remainder", bus_if.remainder, lit_r);
  endtask

  initial begin
    logic [W-1:0] a, b, lo;
    rst_n          = 1'b0;
    bus_if.start   = 1'b0;
    bus_if.data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", bus_if.busy, 0);
    checkOutput("reset_done", bus_if.done, 0);
    checkOutput("reset_quotient", bus_if.quotient, 0);
    checkOutput("reset_remainder", bus_if.remainder, 0);
    checkOutput("reset_dz", bus_if.dz, 0);
    rst_n = 1'b1;

    runDirected(16'd4, 16'd25, 6, 1, 1'b0);
    checkOutput("lat_25_4", exp_lat, 8);
    runDirected(16'd25, 16'd4, 0, 4, 1'b0);
    runDirected(16'd4, 16'd24, 6, 0, 1'b0);
`ifdef DIV_ZERO_DETECT_EN
    runDirected(16'd1, 16'hFFFF, 16'hFFFF, 0, 1'b0);
    runDirected(16'd0, 16'd7, 16'hFFFF, 7, 1'b0);
    checkOutput("lit_dz", bus_if.dz, 1);
`else
    runDirected(16'd257, 16'hFFFF, 255, 0, 1'b0);
    runDirected(16'd0, 16'd7, 16'hFFFF, 7, 1'b0);
    checkOutput("lit_dz", bus_if.dz, 0);
`endif

    // Result must hold while idling in DONE
    repeat (5) @(posedge clk);
    #1;
    checkOutput("done_held", bus_if.done, 1);
    checkOutput("held_remainder", bus_if.remainder, 7);

    // Abort a long division with reset in the middle of CALC
    @(posedge clk); #1;
    exp_valid      = 1'b0;
    bus_if.start   = 1'b1;
    bus_if.data_in = 16'd3;
    @(posedge clk); #1;
    bus_if.start   = 1'b0;
    bus_if.data_in = 16'd200;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("busy_mid_calc", bus_if.busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_busy", bus_if.busy, 0);
    checkOutput("abort_done", bus_if.done, 0);
    checkOutput("abort_quotient", bus_if.quotient, 0);
    checkOutput("abort_remainder", bus_if.remainder, 0);
    checkOutput("abort_dz", bus_if.dz, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle_after_abort_busy", bus_if.busy, 0);
    checkOutput("idle_after_abort_done", bus_if.done, 0);
    runDirected(16'd2, 16'd9, 4, 1, 1'b0);

    runDirected(16'd7, 16'd100, 14, 2, 1'b1);
    checkOutput("done_before_b2b", bus_if.done, 1);
    runDirected(16'd3, 16'd10, 3, 1, 1'b0);

    for (int i = 0; i < 20; i++) begin
      a  = W'($urandom_range(0, 65535));
      lo = (a >> 6) == 0 ? W'(1) : (a >> 6);
      b  = W'($urandom_range(65535, int'(lo)));
      applyStimulus(b, a, 1'(i % 3 == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
